// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame constants and tick accumulator width.
// Used by both the receiver and the transmitter.
package uart_pkg;

  localparam int DATA_BITS  = 8;
  localparam int TICK_ACC_W = 29;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } uart_state_e;

  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Host/pin-side signal bundle of the UART receiver.
// The master modport is the host and line driver; the slave modport is the receiver.
interface uart_rx_if;
  import uart_pkg::*;

  logic                 uart_rx_i;
  logic                 uart_rd_i;
  logic [DATA_BITS-1:0] uart_dat_o;
  logic                 uart_rdy_o;
  logic                 uart_busy_o;
  logic                 uart_frame_err_o;
  logic                 uart_overrun_o;
  logic                 uart_parity_err_o;

  modport master (
    output uart_rx_i, uart_rd_i,
    input  uart_dat_o, uart_rdy_o, uart_busy_o,
    input  uart_frame_err_o, uart_overrun_o, uart_parity_err_o
  );

  modport slave (
    input  uart_rx_i, uart_rd_i,
    output uart_dat_o, uart_rdy_o, uart_busy_o,
    output uart_frame_err_o, uart_overrun_o, uart_parity_err_o
  );

endinterface

// File: rtl/uart_baud_tick.sv
// Fractional baud tick generator: pulses tick_o at BAUD*OVERSAMPLE Hz on average.
// Free-running phase accumulator; only the system reset clears it.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115_200,
  parameter int OVERSAMPLE = 16
) (
  input  logic sys_clk_i,
  input  logic sys_rst_i,
  output logic tick_o
);

  localparam logic [TICK_ACC_W-1:0] STEP  = TICK_ACC_W'(BAUD * OVERSAMPLE);
  localparam logic [TICK_ACC_W-1:0] LIMIT = TICK_ACC_W'(CLK_HZ);

  logic [TICK_ACC_W-1:0] acc;
  logic [TICK_ACC_W-1:0] sum;

  assign sum = acc + STEP;

  // NOTE: registers use non-blocking assignments so every process sees pre-edge values.
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      acc    <= '0;
      tick_o <= 1'b0;
    end else if (sum >= LIMIT) begin
      acc    <= sum - LIMIT;
      tick_o <= 1'b1;
    end else begin
      acc    <= sum;
      tick_o <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1, LSB first, 16x oversampled with mid-bit sampling.
// Define UART_RX_PARITY_EN for 8E1 (even parity state and uart_parity_err_o pulse).
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115_200,
  parameter int OVERSAMPLE = 16
) (
  input logic      sys_clk_i,
  input logic      sys_rst_i,
  uart_rx_if.slave bus
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] MID_START = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] MID_BIT   = CNT_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] LAST_BIT  = IDX_W'(DATA_BITS - 1);

  logic tick;

  uart_baud_tick #(
    .CLK_HZ    (CLK_HZ),
    .BAUD      (BAUD),
    .OVERSAMPLE(OVERSAMPLE)
  ) u_baud_tick (
    .sys_clk_i(sys_clk_i),
    .sys_rst_i(sys_rst_i),
    .tick_o   (tick)
  );

  // Two-flop synchronizer; resets to the idle-high line level.
  logic [1:0] rx_sync;
  logic       line;

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) rx_sync <= 2'b11;
    else           rx_sync <= {rx_sync[0], bus.uart_rx_i};
  end

  assign line = rx_sync[1];

  uart_state_e          state, state_n;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic [IDX_W-1:0]     idx, idx_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic                 deliver, frame_bad;
`ifdef UART_RX_PARITY_EN
  logic                 parity_bad, parity_bad_n;
`endif

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      state <= ST_IDLE;
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
`ifdef UART_RX_PARITY_EN
      parity_bad <= 1'b0;
`endif
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      shreg <= shreg_n;
`ifdef UART_RX_PARITY_EN
      parity_bad <= parity_bad_n;
`endif
    end
  end

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    idx_n     = idx;
    shreg_n   = shreg;
    deliver   = 1'b0;
    frame_bad = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_bad_n = parity_bad;
`endif
    unique case (state)
      ST_IDLE: begin
        if (!line) begin
          state_n = ST_START;
          cnt_n   = '0;
        end
      end
      ST_START: begin
        if (tick) begin
          if (cnt == MID_START) begin
            cnt_n = '0;
            idx_n = '0;
            state_n = line ? ST_IDLE : ST_DATA;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (cnt == MID_BIT) begin
            cnt_n          = '0;
            shreg_n[idx]   = line;
            if (idx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
              state_n = ST_PARITY;
`else
              state_n = ST_STOP;
`endif
            end else begin
              idx_n = idx + 1'b1;
            end
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (tick) begin
          if (cnt == MID_BIT) begin
            cnt_n        = '0;
            parity_bad_n = (line != even_parity(shreg));
            state_n      = ST_STOP;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end
`endif
      ST_STOP: begin
        if (tick) begin
          if (cnt == MID_BIT) begin
            cnt_n = '0;
            if (line) begin
              deliver = 1'b1;
              state_n = ST_IDLE;
            end else begin
              frame_bad = 1'b1;
              state_n   = ST_BREAK;
            end
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end
      ST_BREAK: begin
        if (line) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  logic [DATA_BITS-1:0] dat_q;
  logic                 rdy_q, overrun_q, frame_err_q;

  // A delivery beats a same-cycle read; the read still clears a pending overrun.
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      dat_q       <= '0;
      rdy_q       <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= frame_bad;
      if (deliver) begin
        dat_q <= shreg;
        rdy_q <= 1'b1;
        if (bus.uart_rd_i)  overrun_q <= 1'b0;
        else if (rdy_q)     overrun_q <= 1'b1;
      end else if (bus.uart_rd_i && rdy_q) begin
        rdy_q     <= 1'b0;
        overrun_q <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  logic parity_err_q;

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) parity_err_q <= 1'b0;
    else           parity_err_q <= deliver && parity_bad;
  end

  assign bus.uart_parity_err_o = parity_err_q;
`else
  assign bus.uart_parity_err_o = 1'b0;
`endif

  assign bus.uart_dat_o       = dat_q;
  assign bus.uart_rdy_o       = rdy_q;
  assign bus.uart_overrun_o   = overrun_q;
  assign bus.uart_frame_err_o = frame_err_q;
  assign bus.uart_busy_o      = (state != ST_IDLE);

endmodule
